// File: rtl/life_gen_sequencer_if.sv
// Board/datapath-facing signal bundle for the Life generation sequencer.
// Master drives controls and the datapath result; slave is the sequencer.
interface life_gen_sequencer_if #(
    parameter int GEN_W = 16
);
    logic             load;
    logic [63:0]      seed;
    logic             run;
    logic             step;
    logic [63:0]      next_grid;
    logic [63:0]      grid;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             halted;
    logic             extinct;
    logic             stable;

    modport master (
        output load, seed, run, step, next_grid,
        input  grid, gen_count, busy, halted, extinct, stable
    );

    modport slave (
        input  load, seed, run, step, next_grid,
        output grid, gen_count, busy, halted, extinct, stable
    );
endinterface

// File: rtl/life_gen_sequencer.sv
// Generation controller for the 8x8 Life grid: owns the grid register and
// decides when the combinational next-generation result is committed.
//
// state | meaning
// PAUSE | grid held; a step pulse commits one generation
// RUN   | free-run, one generation every DIV cycles
// HALT  | grid went still or extinct; only load or reset leaves
module life_gen_sequencer #(
    parameter int DIV       = 10,
    parameter int GEN_W     = 16,
    parameter int AUTO_HALT = 1
) (
    input logic                 clk,
    input logic                 reset,
    life_gen_sequencer_if.slave bus
);
    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             tick;
    logic             want_adv;
    logic             halt_hit;

    assign tick     = (cnt_q == CNT_LAST);
    assign halt_hit = (AUTO_HALT != 0) && bus.stable;

    // An advance opportunity; load pre-empts it and the halt check may veto it.
    assign want_adv = !bus.load &&
                      (((state_q == PAUSE) && !bus.run && bus.step) ||
                       ((state_q == RUN) && bus.run && tick));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = bus.run ? RUN : PAUSE;
        end else begin
            case (state_q)
                PAUSE: begin
                    if (bus.run)                   state_d = RUN;
                    else if (want_adv && halt_hit) state_d = HALT;
                end
                RUN: begin
                    if (!bus.run)                  state_d = PAUSE;
                    else if (want_adv && halt_hit) state_d = HALT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        grid_d = grid_q;
        gen_d  = gen_q;
        cnt_d  = cnt_q;
        if (bus.load) begin
            grid_d = bus.seed;
            gen_d  = '0;
            cnt_d  = '0;
        end else begin
            if (want_adv && !halt_hit) begin
                grid_d = bus.next_grid;
                gen_d  = gen_q + 1'b1;
            end
            case (state_q)
                PAUSE:   cnt_d = '0;
                RUN:     cnt_d = (!bus.run || tick) ? '0 : cnt_q + 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grid_q <= '0;
            gen_q  <= '0;
            cnt_q  <= '0;
        end else begin
            grid_q <= grid_d;
            gen_q  <= gen_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.grid      = grid_q;
    assign bus.gen_count = gen_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.halted    = (state_q == HALT);
    assign bus.extinct   = (grid_q == 64'd0);
    assign bus.stable    = (bus.next_grid == grid_q);
endmodule

// File: tb/tb_life_gen_sequencer.sv
// Scoreboard bench for life_gen_sequencer with a rotate-left stub datapath;
// two instances cover the default build and a DIV=1, 4-bit counter build.
module tb_life_gen_sequencer;
    localparam logic [63:0] SEED  = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] SEED3 = 64'h2093_2120_01A1_E140;
    localparam logic [63:0] SEED2 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    life_gen_sequencer_if #(.GEN_W(16)) ia ();
    life_gen_sequencer_if #(.GEN_W(4))  ib ();

    assign ia.next_grid = {ia.grid[62:0], ia.grid[63]};
    assign ib.next_grid = {ib.grid[62:0], ib.grid[63]};

    life_gen_sequencer #(.DIV(10), .GEN_W(16), .AUTO_HALT(1)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ia.slave)
    );

    life_gen_sequencer #(.DIV(1), .GEN_W(4), .AUTO_HALT(0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ib.slave)
    );

    typedef struct {
        string       name;
        bit          sel;
        logic [63:0] grid;
        logic [15:0] gen;
        logic        busy;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[62:0], r[63]};
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_x(input string name, input bit sel, input logic [63:0] g,
                            input logic [15:0] n, input logic b, input logic h);
        exp_t e;
        e.name   = name;
        e.sel    = sel;
        e.grid   = g;
        e.gen    = n;
        e.busy   = b;
        e.halted = h;
        sb.push_back(e);
    endtask

    // Monitor: registered outputs are settled by the falling edge.
    initial begin : monitor
        exp_t        e;
        logic [63:0] ag;
        logic [15:0] an;
        logic        ab, ah, ax;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    ag = ib.grid; an = {12'd0, ib.gen_count};
                    ab = ib.busy; ah = ib.halted; ax = ib.extinct;
                end else begin
                    ag = ia.grid; an = ia.gen_count;
                    ab = ia.busy; ah = ia.halted; ax = ia.extinct;
                end
                checks++;
                if (ag !== e.grid || an !== e.gen || ab !== e.busy ||
                    ah !== e.halted || ax !== (e.grid == 64'd0)) begin
                    errors++;
                    $display("FAIL %s: got grid=%h gen=%0d busy=%b halted=%b extinct=%b; want grid=%h gen=%0d busy=%b halted=%b extinct=%b",
                             e.name, ag, an, ab, ah, ax,
                             e.grid, e.gen, e.busy, e.halted, (e.grid == 64'd0));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_a = 1'b1; rst_b = 1'b1;
        ia.load = 1'b0; ia.seed = '0; ia.run = 1'b0; ia.step = 1'b0;
        ib.load = 1'b0; ib.seed = '0; ib.run = 1'b0; ib.step = 1'b0;

        // reset
        cyc(2);
        rst_a = 1'b0; rst_b = 1'b0;
        expect_x("reset", 0, 64'd0, 16'd0, 1'b0, 1'b0);
        cyc(1);
        expect_x("reset_idle", 0, 64'd0, 16'd0, 1'b0, 1'b0);

        // seed load and single steps
        ia.seed = SEED; ia.load = 1'b1;
        cyc(1);
        ia.load = 1'b0;
        expect_x("load_pause", 0, SEED, 16'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            ia.step = 1'b1;
            cyc(1);
            ia.step = 1'b0;
            expect_x("step", 0, rotl(SEED, k), 16'(k), 1'b0, 1'b0);
            cyc(1);
        end
        expect_x("step3_const", 0, SEED3, 16'd3, 1'b0, 1'b0);

        // free-run at DIV=10
        ia.seed = SEED; ia.load = 1'b1; ia.run = 1'b1;
        cyc(1);
        ia.load = 1'b0;
        expect_x("run_entry", 0, SEED, 16'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 41; k++) begin
            cyc(1);
            if (k % 10 == 9 || k % 10 == 0 || k == 41)
                expect_x("run_div", 0, rotl(SEED, k / 10), 16'(k / 10), 1'b1, 1'b0);
        end
        ia.run = 1'b0;
        cyc(1);
        expect_x("run_stop", 0, rotl(SEED, 4), 16'd4, 1'b0, 1'b0);
        cyc(20);
        expect_x("pause_hold", 0, rotl(SEED, 4), 16'd4, 1'b0, 1'b0);

        // auto-halt on a still grid
        ia.seed = ONES; ia.load = 1'b1; ia.run = 1'b1;
        cyc(1);
        ia.load = 1'b0;
        expect_x("ones_entry", 0, ONES, 16'd0, 1'b1, 1'b0);
        cyc(9);
        expect_x("ones_pre", 0, ONES, 16'd0, 1'b1, 1'b0);
        cyc(1);
        expect_x("halt", 0, ONES, 16'd0, 1'b0, 1'b1);
        ia.run = 1'b0; ia.step = 1'b1;
        cyc(1);
        ia.step = 1'b0;
        cyc(1);
        ia.run = 1'b1; ia.step = 1'b1;
        cyc(1);
        ia.step = 1'b0;
        cyc(12);
        expect_x("halt_hold", 0, ONES, 16'd0, 1'b0, 1'b1);
        ia.seed = SEED; ia.load = 1'b1;
        cyc(1);
        ia.load = 1'b0;
        expect_x("halt_exit", 0, SEED, 16'd0, 1'b1, 1'b0);

        // load on the divider terminal cycle
        cyc(9);
        expect_x("pre_tick", 0, SEED, 16'd0, 1'b1, 1'b0);
        ia.seed = SEED2; ia.load = 1'b1;
        cyc(1);
        ia.load = 1'b0;
        expect_x("load_on_tick", 0, SEED2, 16'd0, 1'b1, 1'b0);
        cyc(9);
        expect_x("after_load_9", 0, SEED2, 16'd0, 1'b1, 1'b0);
        cyc(1);
        expect_x("after_load_10", 0, rotl(SEED2, 1), 16'd1, 1'b1, 1'b0);

        // run dropped on the divider terminal cycle
        cyc(9);
        ia.run = 1'b0;
        cyc(1);
        expect_x("stop_on_tick", 0, rotl(SEED2, 1), 16'd1, 1'b0, 1'b0);

        // run rising together with a step
        ia.seed = SEED; ia.load = 1'b1;
        cyc(1);
        ia.load = 1'b0;
        expect_x("load_paused", 0, SEED, 16'd0, 1'b0, 1'b0);
        ia.run = 1'b1; ia.step = 1'b1;
        cyc(1);
        ia.step = 1'b0;
        expect_x("run_step_same", 0, SEED, 16'd0, 1'b1, 1'b0);
        cyc(9);
        expect_x("rs_9", 0, SEED, 16'd0, 1'b1, 1'b0);
        cyc(1);
        expect_x("rs_10", 0, rotl(SEED, 1), 16'd1, 1'b1, 1'b0);

        // reset in the middle of a run, then halt on the extinct grid
        ia.seed = SEED; ia.load = 1'b1;
        cyc(1);
        ia.load = 1'b0;
        cyc(5);
        rst_a = 1'b1; ia.run = 1'b0;
        cyc(1);
        rst_a = 1'b0;
        expect_x("reset_mid_run", 0, 64'd0, 16'd0, 1'b0, 1'b0);
        ia.run = 1'b1;
        cyc(1);
        expect_x("zero_run", 0, 64'd0, 16'd0, 1'b1, 1'b0);
        cyc(9);
        expect_x("extinct_pre", 0, 64'd0, 16'd0, 1'b1, 1'b0);
        cyc(1);
        expect_x("extinct_halt", 0, 64'd0, 16'd0, 1'b0, 1'b1);
        ia.run = 1'b0;

        // DIV=1, 4-bit counter wrap
        ib.seed = 64'd1; ib.load = 1'b1; ib.run = 1'b1;
        cyc(1);
        ib.load = 1'b0;
        expect_x("b_entry", 1, 64'd1, 16'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            if (k == 1 || k == 15 || k == 16)
                expect_x("b_adv", 1, 64'd1 << k, 16'(k % 16), 1'b1, 1'b0);
        end
        ib.run = 1'b0;
        cyc(1);
        expect_x("b_stop", 1, 64'd1 << 16, 16'd0, 1'b0, 1'b0);

        cyc(3);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
Generation controller for the 64-bit (8x8) Life grid datapath. Owns the grid state register and feeds it to the combinational next-generation logic. Sequences when that logic's result is committed: seed load, free-run at a divided rate, single-step, and auto-halt on a still or extinct grid. Sits between the board switches/buttons and the next-state datapath, and drives the display.

Parameters:
DIV, 10, clock cycles per generation while running; legal range ≥1
GEN_W, 16, width of the generation counter
AUTO_HALT, 1, 1 = halt when the next grid equals the current grid; 0 = never halt

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  level; load seed into the grid this cycle
seed  input  64  initial grid pattern
run  input  1  level switch; 1 = free-run, 0 = pause
step  input  1  single-cycle pulse; advance one generation while paused
next_grid  input  64  next generation of grid, from the combinational datapath
grid  output  64  current generation, registered
gen_count  output  GEN_W  generations committed since the last load or reset
busy  output  1  1 while in RUN
halted  output  1  1 while in HALT
extinct  output  1  combinational: grid == 0
stable  output  1  combinational: next_grid == grid

Behaviour:
- FSM states: PAUSE, RUN, HALT. Divider counter cnt spans 0..DIV-1.
- Reset, sampled at a clock edge:
  - grid=0, gen_count=0, cnt=0, state=PAUSE.
  - busy=0, halted=0.
  - extinct=1; stable follows the datapath (1 for a correct Life datapath).
- Priority each cycle: reset > load > state-machine action.
- load=1:
  - grid<=seed, gen_count<=0, cnt<=0.
  - Next state: RUN if run=1, else PAUSE. Valid from any state, including HALT.
  - A step or divider expiry in the same cycle is discarded.
- "Advance" means grid<=next_grid and gen_count<=gen_count+1. gen_count wraps modulo 2^GEN_W.
- Halt check: if AUTO_HALT=1 and stable=1 when an advance would occur:
  - Go to HALT instead of advancing.
  - grid and gen_count are unchanged.
- PAUSE:
  - run=1: go to RUN, cnt<=0. A step in that same cycle is ignored.
  - run=0 and step=1: one advance, or the halt check. Stay in PAUSE.
  - Holding step high for N cycles gives N advances; the bench must pulse it.
- RUN:
  - run=0: go to PAUSE, cnt<=0, no advance that cycle, even if cnt==DIV-1.
  - Otherwise, when cnt==DIV-1: advance (or halt check) and cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - step is ignored.
  - The first advance happens DIV cycles after the edge that entered RUN.
  - DIV=1 gives an advance every cycle.
- HALT:
  - grid, gen_count and cnt are held. run and step are ignored.
  - Exit only via load or reset.
- busy = (state==RUN). halted = (state==HALT). Both are decoded from registered state.

Test Plan:
1. Hold reset 2 cycles, then release → grid=0, gen_count=0, busy=0, halted=0, extinct=1.
   - The bench stub datapath for tests 2–6 is next_grid = rotate-left-by-1 of grid.
2. Load seed=64'h0412_6424_0034_3C28 with run=0, then 3 step pulses spaced 2 cycles apart:
   - gen_count=3.
   - grid = seed rotated left 3 = 64'h2093_2120_01A1_E140.
   - busy=0 throughout.
3. DIV=10, load seed, set run=1 and hold for 41 cycles after RUN entry, then run=0:
   - Advances at cycles 10, 20, 30 and 40; gen_count=4.
   - busy falls on the edge after run=0; gen_count stays 4 for 20 more cycles.
4. AUTO_HALT=1, load 64'hFFFF_FFFF_FFFF_FFFF, run=1:
   - At cycle 10: halted=1, busy=0, gen_count=0, grid unchanged.
   - Toggling run and step has no effect.
   - Loading seed 64'h0412_6424_0034_3C28 with run=1 gives halted=0, busy=1, gen_count=0.
5. Simultaneous events:
   - load=1 on the same cycle cnt==DIV-1 → grid=seed, gen_count=0, no advance.
   - run 0→1 on the same cycle as a step → no advance; the first advance comes DIV cycles later.
6. Reset mid-RUN at cnt=5 → next cycle: grid=0, gen_count=0, PAUSE, cnt=0.
   - GEN_W=4, AUTO_HALT=0, DIV=1, 16 advances from a non-zero seed → gen_count wraps to 0.
